dir_key_queue: RTL and testbench
================================

# dir_key_queue

Parametrised direction-input front end for the game controllers. Synchronises and debounces four raw direction keys, turns clean presses into direction commands, filters duplicates and illegal reversals, and buffers accepted commands in a small FIFO. Each game-step `tick` consumes one command, so quick key sequences between steps are applied in order rather than lost. It sits between the board push-buttons and the game-logic step engine.

## Interface
- `DEBOUNCE_CNT`, 20'd999_999: cycles a synchronised key level must stay unchanged before it is accepted (20 ms at 50 MHz).
- `CNT_W`, 20: debounce counter width; must hold `DEBOUNCE_CNT`.
- `KEY_ACTIVE_LOW`, 0: 1 means raw keys read 0 when pressed.
- `QUEUE_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PTR_W`, 2: log2(`QUEUE_DEPTH`).
- `INIT_DIR`, 2'd0: direction after reset.
- `ALLOW_REVERSE`, 0: 1 disables the reversal filter.
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `key_up`, `key_down`, `key_left`, `key_right` in 1 each: raw asynchronous buttons.
- `tick` in 1: one-cycle game-step strobe, synchronous to `sys_clk`.
- `direction` out 2: current applied direction. Encoding: up 2'd0, down 2'd1, left 2'd2, right 2'd3.
- `dir_changed` out 1: one-cycle pulse when `direction` is loaded from the queue.
- `key_state` out 4: debounced levels {right,left,down,up}, 1 = pressed.
- `key_pulse` out 4: one-cycle debounced press pulses, same bit order.
- `queue_count` out PTR_W+1: entries held, 0..`QUEUE_DEPTH`.
- `overflow` out 1: sticky; set when a valid command is dropped because the queue is full; cleared only by reset.

## Operation
- **Synchronise:** each key uses a 2-flop synchroniser, then is normalised to active-high using `KEY_ACTIVE_LOW`.
- **Debounce (per key):**
  - The counter clears whenever the synchronised level differs from the stable level and the two last samples differ; otherwise it increments while the level differs from the stable level.
  - When the count reaches `DEBOUNCE_CNT`, the stable level takes the new value and the counter clears.
  - The counter holds at 0 while the level equals the stable level.
- **Press pulse:** `key_pulse[i]` fires for one cycle on a stable 0→1 transition. Releases produce no pulse.
- **Candidate command:** valid only when exactly one `key_pulse` bit is set and `key_state` has exactly that single bit set. Any multi-key press or chord is ignored.
- **Reference direction:** the last enqueued entry if the queue is non-empty, else `direction`. It is evaluated from pre-cycle state.
- **Filter:**
  - Drop the candidate if it equals the reference direction.
  - Drop it if it equals reference ^ 2'b01 (reversal), unless `ALLOW_REVERSE`=1.
  - Filtered drops do not set `overflow`.
- **Push:** a surviving candidate is written at the tail. If the queue is full and no pop occurs this cycle, the candidate is dropped and `overflow` is set.
- **Pop:**
  - On `tick` with `queue_count`>0 (pre-cycle), the head entry loads into `direction` and `dir_changed` pulses.
  - On `tick` with an empty queue, `direction` holds and no pulse is generated.
- **Simultaneous push and pop:**
  - Both occur; count is unchanged.
  - If the queue is full, the freed slot accepts the push and `overflow` is not set.
  - If the queue is empty, the push is stored and the pop is a no-op; the new entry is applied on the next `tick`.
- **Pointers:** PTR_W-bit head and tail wrap modulo `QUEUE_DEPTH`; `queue_count` is tracked separately.

## Timing
- **Reset values:**
  - `direction`=`INIT_DIR`; `dir_changed`, `key_pulse`, `overflow`=0; `queue_count`=0.
  - `key_state`=0; synchronisers reset to the released level; counters and pointers=0.
- **Press latency:** a raw edge held stable reaches `key_state` 2 + `DEBOUNCE_CNT` + 1 cycles later (±1 for synchroniser phase).
- **Pulse timing:** `key_pulse` is asserted in the same cycle `key_state` rises.
- **Enqueue:** the queue entry is written, and `queue_count` updated, one cycle after `key_pulse`.
- **Tick response:** `direction` and `dir_changed` update in the cycle after `tick` is sampled.
- **Mid-operation reset:** asynchronous reset at any point clears the queue and all outputs immediately. No stale command survives reset.
- **Glitches:** bounces shorter than `DEBOUNCE_CNT` cycles never change `key_state`.

## Test plan
Bench uses `DEBOUNCE_CNT`=7, `QUEUE_DEPTH`=4, `INIT_DIR`=up.
- **Bounce rejection:** `key_left` toggled every 3 cycles for 30 cycles, then held high 20 cycles → exactly one `key_pulse[2]`, `queue_count` 0→1; after `tick`, `direction`=2'd2 and one `dir_changed`.
- **Reversal and duplicate filter:** from `direction`=up, press down, then press up → `queue_count` stays 0, no `overflow`. Repeat with `ALLOW_REVERSE`=1 → down is queued.
- **Ordered queue:** with no ticks, press left, down, right (each with a clean release) → `queue_count`=3. Three ticks give `direction` 2, 1, 3 on successive `dir_changed` pulses. A fourth tick → no pulse, `direction`=3.
- **Overflow:** fill 4 alternating legal entries (left, up, right, up), then press a legal fifth → entry dropped, `overflow`=1, `queue_count`=4. Repeat with the fifth push coincident with `tick` → accepted, `overflow` stays 0, count stays 4.
- **Chord rejection:** `key_up` and `key_left` rise in the same cycle, held 20 cycles → both `key_pulse` bits fire together, nothing queued.
- **Reset mid-queue:** with `queue_count`=2, assert `sys_rst_n`=0 for 1 cycle → `queue_count`=0, `direction`=up, `overflow`=0 immediately. A subsequent `tick` → no `dir_changed`.

Source files
------------

// File: rtl/dir_key_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dir_key_queue
//  Description : Direction-key front end. Synchronises and debounces four raw
//                keys, turns clean single-key presses into direction commands,
//                filters duplicates and reversals, and queues the accepted
//                commands so that each game-step tick applies one of them.
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_key_queue #(
    parameter int              CNT_W          = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CNT  = 20'd999_999,
    parameter int              KEY_ACTIVE_LOW = 0,
    parameter int              QUEUE_DEPTH    = 4,
    parameter int              PTR_W          = 2,
    parameter logic [1:0]      INIT_DIR       = 2'd0,
    parameter int              ALLOW_REVERSE  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             tick,
    output logic [1:0]       direction,
    output logic             dir_changed,
    output logic [3:0]       key_state,
    output logic [3:0]       key_pulse,
    output logic [PTR_W:0]   queue_count,
    output logic             overflow
);

    // Raw pin level of a released key; synchronisers idle at this value.
    localparam logic           C_RELEASED_LVL = (KEY_ACTIVE_LOW != 0);
    localparam logic [PTR_W:0] C_FULL_CNT     = (PTR_W+1)'(QUEUE_DEPTH);

    logic [3:0] w_key_raw;
    logic [3:0] w_stable;
    logic [3:0] w_pulse;

    assign w_key_raw = {key_right, key_left, key_down, key_up};

    // ------------------------------------------------------------------------
    // Per-key synchroniser, debouncer and press-edge detector
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        logic             sync1_q, sync2_q;
        logic             prev_q;
        logic             stable_q, stable_d;
        logic             pulse_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             w_level;

        // Normalised active-high level after the synchroniser.
        assign w_level = sync2_q ^ C_RELEASED_LVL;

        // Debounce: count only while the new level is steady, restart on bounce.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (w_level != stable_q) begin
                if (w_level != prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEBOUNCE_CNT) begin
                    stable_d = w_level;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Key state registers; pulse rises together with the stable level.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1_q  <= C_RELEASED_LVL;
                sync2_q  <= C_RELEASED_LVL;
                prev_q   <= 1'b0;
                stable_q <= 1'b0;
                pulse_q  <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= w_key_raw[gi];
                sync2_q  <= sync1_q;
                prev_q   <= w_level;
                stable_q <= stable_d;
                pulse_q  <= stable_d & ~stable_q;
                cnt_q    <= cnt_d;
            end
        end

        assign w_stable[gi] = stable_q;
        assign w_pulse[gi]  = pulse_q;
    end

    assign key_state = w_stable;
    assign key_pulse = w_pulse;

    // ------------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------------
    logic [1:0]       mem_q [QUEUE_DEPTH];
    logic [1:0]       mem_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, w_last;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       dir_q, dir_d;
    logic             chg_q, chg_d;
    logic             ovf_q, ovf_d;
    logic             w_cand_valid, w_accept, w_pop, w_push, w_drop_full;
    logic [1:0]       w_cand_dir, w_ref_dir;

    assign w_last    = tail_q - 1'b1;
    assign w_ref_dir = (count_q != '0) ? mem_q[w_last] : dir_q;

    // Decode a lone clean press into a direction; chords never qualify.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_dir   = 2'd0;
        if (key_state == key_pulse) begin
            case (key_pulse)
                4'b0001: begin w_cand_valid = 1'b1; w_cand_dir = 2'd0; end
                4'b0010: begin w_cand_valid = 1'b1; w_cand_dir = 2'd1; end
                4'b0100: begin w_cand_valid = 1'b1; w_cand_dir = 2'd2; end
                4'b1000: begin w_cand_valid = 1'b1; w_cand_dir = 2'd3; end
                default: begin w_cand_valid = 1'b0; w_cand_dir = 2'd0; end
            endcase
        end
    end

    assign w_accept    = w_cand_valid && (w_cand_dir != w_ref_dir) &&
                         ((ALLOW_REVERSE != 0) || (w_cand_dir != (w_ref_dir ^ 2'b01)));
    assign w_pop       = tick && (count_q != '0);
    assign w_push      = w_accept && ((count_q != C_FULL_CNT) || w_pop);
    assign w_drop_full = w_accept && (count_q == C_FULL_CNT) && !w_pop;

    // Next-state for the FIFO, applied direction and sticky overflow.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dir_d   = dir_q;
        chg_d   = 1'b0;
        ovf_d   = ovf_q | w_drop_full;
        if (w_push) begin
            mem_d[tail_q] = w_cand_dir;
            tail_d        = tail_q + 1'b1;
        end
        if (w_pop) begin
            dir_d  = mem_q[head_q];
            chg_d  = 1'b1;
            head_d = head_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue and output registers; reset empties the queue immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dir_q   <= INIT_DIR;
            chg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            chg_q   <= chg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign direction   = dir_q;
    assign dir_changed = chg_q;
    assign queue_count = count_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dir_key_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dir_key_queue
//  Description : Directed self-checking bench for dir_key_queue with a
//                scoreboard of expected applied directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dir_key_queue;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       key_up, key_down, key_left, key_right, tick;
    logic [1:0] direction, direction2;
    logic       dir_changed, dir_changed2, overflow, overflow2;
    logic [3:0] key_state, key_pulse, key_state2, key_pulse2;
    logic [2:0] queue_count, queue_count2;

    int errors = 0;
    int checks = 0;
    logic [1:0] sb[$];

    dir_key_queue #(
        .CNT_W(20), .DEBOUNCE_CNT(20'd7), .KEY_ACTIVE_LOW(0), .QUEUE_DEPTH(4),
        .PTR_W(2), .INIT_DIR(2'd0), .ALLOW_REVERSE(0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_up(key_up),
        .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .tick(tick), .direction(direction), .dir_changed(dir_changed),
        .key_state(key_state), .key_pulse(key_pulse),
        .queue_count(queue_count), .overflow(overflow)
    );

    dir_key_queue #(
        .CNT_W(20), .DEBOUNCE_CNT(20'd7), .KEY_ACTIVE_LOW(0), .QUEUE_DEPTH(4),
        .PTR_W(2), .INIT_DIR(2'd0), .ALLOW_REVERSE(1)
    ) dut_rev (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_up(key_up),
        .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .tick(tick), .direction(direction2), .dir_changed(dir_changed2),
        .key_state(key_state2), .key_pulse(key_pulse2),
        .queue_count(queue_count2), .overflow(overflow2)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_up    = v;
            1: key_down  = v;
            2: key_left  = v;
            default: key_right = v;
        endcase
    endtask

    // Compare the cycle after a sampled tick against the scoreboard head.
    task automatic check_pop();
        logic [1:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dir_changed_on_pop", dir_changed, 1);
            chk("direction_on_pop", direction, e);
        end else begin
            chk("no_dir_changed_empty", dir_changed, 0);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check_pop();
        cyc();
        chk("dir_changed_one_cycle", dir_changed, 0);
    endtask

    // Clean press and release of key k; optional tick aligned with the enqueue.
    task automatic press(input int k, input bit tick_on_pulse);
        int         npulse;
        logic [3:0] seen;
        logic [3:0] onehot;
        npulse = 0;
        seen   = '0;
        onehot = 4'b0001 << k;
        set_key(k, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick) begin
                tick = 1'b0;
                check_pop();
            end
            if (key_pulse != 4'b0000) begin
                npulse++;
                seen = key_pulse;
                if (tick_on_pulse) tick = 1'b1;
            end
        end
        chk("press_pulse_count", 8'(npulse), 1);
        chk("press_pulse_bit", {4'b0, seen}, {4'b0, onehot});
        set_key(k, 1'b0);
        repeat (20) cyc();
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        #2;
        chk("rst_queue_count", queue_count, 0);
        chk("rst_direction", direction, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dir_changed", dir_changed, 0);
        sb.delete();
        cyc();
        sys_rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int npulse;
        logic [3:0] chord;
        sys_rst_n = 1'b0;
        {key_up, key_down, key_left, key_right, tick} = '0;
        repeat (3) cyc();
        chk("reset_direction", direction, 0);
        chk("reset_queue_count", queue_count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_key_state", key_state, 0);
        chk("reset_key_pulse", key_pulse, 0);
        chk("reset_dir_changed", dir_changed, 0);
        sys_rst_n = 1'b1;
        cyc();

        // Bounce rejection on left
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            key_left = ((i / 3) % 2 == 0);
            cyc();
            if (key_pulse != 4'b0000) npulse++;
        end
        chk("bounce_key_state_idle", key_state, 0);
        key_left = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (key_pulse == 4'b0100) npulse++;
            else if (key_pulse != 4'b0000) npulse += 100;
        end
        chk("bounce_single_pulse", 8'(npulse), 1);
        chk("bounce_count", queue_count, 1);
        key_left = 1'b0;
        repeat (20) cyc();
        sb.push_back(2'd2);
        do_tick();

        // Reversal and duplicate filter
        press(0, 0); sb.push_back(2'd0);
        do_tick();
        press(1, 0);
        chk("reverse_dropped", queue_count, 0);
        chk("reverse_allowed_queued", queue_count2, 1);
        press(0, 0);
        chk("duplicate_dropped", queue_count, 0);
        chk("filter_no_overflow", overflow, 0);
        do_tick();

        // Ordered queue
        press(2, 0); sb.push_back(2'd2);
        press(1, 0); sb.push_back(2'd1);
        press(3, 0); sb.push_back(2'd3);
        chk("ordered_count", queue_count, 3);
        do_tick(); do_tick(); do_tick(); do_tick();
        chk("ordered_final_dir", direction, 3);

        // Overflow
        press(0, 0); sb.push_back(2'd0);
        do_tick();
        press(2, 0); sb.push_back(2'd2);
        press(0, 0); sb.push_back(2'd0);
        press(3, 0); sb.push_back(2'd3);
        press(0, 0); sb.push_back(2'd0);
        chk("full_count", queue_count, 4);
        chk("full_no_overflow", overflow, 0);
        press(2, 0);
        chk("overflow_set", overflow, 1);
        chk("overflow_count", queue_count, 4);
        do_tick(); do_tick(); do_tick(); do_tick();
        chk("overflow_sticky", overflow, 1);
        pulse_reset();

        // Full queue with push coincident with tick
        press(2, 0); sb.push_back(2'd2);
        press(0, 0); sb.push_back(2'd0);
        press(3, 0); sb.push_back(2'd3);
        press(0, 0); sb.push_back(2'd0);
        press(2, 1); sb.push_back(2'd2);
        chk("coincident_count", queue_count, 4);
        chk("coincident_no_overflow", overflow, 0);
        do_tick(); do_tick(); do_tick(); do_tick();
        chk("coincident_final_dir", direction, 2);

        // Chord rejection
        npulse = 0;
        chord  = '0;
        key_up = 1'b1; key_left = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (key_pulse != 4'b0000) begin npulse++; chord = key_pulse; end
        end
        chk("chord_pulse_cycles", 8'(npulse), 1);
        chk("chord_pulse_bits", chord, 4'b0101);
        chk("chord_not_queued", queue_count, 0);
        key_up = 1'b0; key_left = 1'b0;
        repeat (20) cyc();

        // Reset mid-queue
        press(0, 0); sb.push_back(2'd0);
        press(3, 0); sb.push_back(2'd3);
        chk("midq_count", queue_count, 2);
        pulse_reset();
        do_tick();
        chk("post_reset_direction", direction, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
